decryption_scheduler: RTL
=========================

DECRYPTION_SCHEDULER -- requirements
Module: decryption_scheduler

Interface
REQ-001 SHALL have parameter D_WIDTH, default 8, character width.
REQ-002 SHALL have parameter START_DECRYPTION_TOKEN, default 8'hFA, end-of-message token.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, max WAIT_BUSY dwell.
REQ-004 SHALL have port clk  in  1  clock, all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port data_i  in  D_WIDTH  incoming ciphertext character.
REQ-007 SHALL have port valid_i  in  1  data_i qualifier.
REQ-008 SHALL have port select_i  in  2  engine select (0 caesar, 1 scytale, 2 zigzag, 3 invalid), sampled on first character of a message.
REQ-009 SHALL have port eng_data_o  out  D_WIDTH  character to engines (shared bus).
REQ-010 SHALL have port eng_valid_o  out  3  one-hot per-engine valid.
REQ-011 SHALL have port eng_busy_i  in  3  per-engine busy.
REQ-012 SHALL have port eng_data_i  in  3*D_WIDTH  engine outputs, engine n at bits [n*D_WIDTH +: D_WIDTH].
REQ-013 SHALL have port eng_valid_i  in  3  per-engine output valid.
REQ-014 SHALL have port data_o / valid_o  out  D_WIDTH / 1  plaintext character and qualifier.
REQ-015 SHALL have port busy_o  out  1  high in WAIT_BUSY and DRAIN.
REQ-016 SHALL have port msg_done_o  out  1  one-cycle pulse at message completion.
REQ-017 SHALL have port out_count_o  out  8  plaintext characters of last message, saturating at 255.
REQ-018 SHALL have port error_o  out  1  one-cycle pulse on invalid select or timeout.
REQ-019 SHALL have port overflow_o  out  1  sticky flag, input dropped while busy_o.

Function
REQ-020 SHALL implement states IDLE, FORWARD, DISCARD, WAIT_BUSY, DRAIN.
REQ-021 IDLE, valid_i, select_i<3: latch sel, forward char; next FORWARD, or WAIT_BUSY if char is token.
REQ-022 IDLE, valid_i, select_i==3: drop char, next DISCARD, or IDLE with error_o pulse if char is token.
REQ-023 FORWARD: forward every valid_i char; token char forwarded, next WAIT_BUSY; select_i ignored.
REQ-024 DISCARD: drop chars; on token pulse error_o, next IDLE; eng_valid_o stays 0.
REQ-025 Forwarding latency 1 cycle: eng_data_o<=data_i, eng_valid_o<=(1<<sel) registered; eng_valid_o 0 otherwise; eng_data_o holds last value.
REQ-026 WAIT_BUSY: counter from 0 each cycle; eng_busy_i[sel]==1 -> DRAIN; count reaching TIMEOUT_CYCLES-1 without busy -> IDLE, error_o pulse.
REQ-027 DRAIN: eng_busy_i[sel] falling (1 seen, now 0) -> IDLE, msg_done_o pulse same cycle as transition.
REQ-028 In WAIT_BUSY and DRAIN, data_o<=eng_data_i[sel], valid_o<=eng_valid_i[sel] registered (1-cycle latency); valid_o 0 in other states; data_o holds.
REQ-029 out_count_o cleared on entering WAIT_BUSY, +1 per forwarded engine valid, saturates 255, holds after DRAIN.
REQ-030 eng_valid_i / eng_busy_i of non-selected engines SHALL be ignored.
REQ-031 valid_i in WAIT_BUSY or DRAIN: char dropped, overflow_o set, cleared only by reset.
REQ-032 Back-to-back: valid_i in cycle msg_done_o asserts SHALL be dropped (state still DRAIN); next cycle accepted in IDLE.

Reset
REQ-033 rst_n low at clock edge: state IDLE, sel 0, counters 0; all outputs 0 (eng_data_o, eng_valid_o, data_o, valid_o, busy_o, msg_done_o, out_count_o, error_o, overflow_o).
REQ-034 Reset mid-message SHALL abandon message with no msg_done_o or error_o pulse.

Verification
REQ-035 select_i=2, chars 41,42,43,FA -> eng_valid_o=3'b100 four cycles, each 1 cycle after input; busy_o high after FA.
REQ-036 Engine 2 busy 1 for 5 cycles, 3 valid outputs 61,62,63 -> data_o same values 1 cycle later, msg_done_o pulse at busy fall, out_count_o=3.
REQ-037 select_i=3, chars 10,FA -> eng_valid_o never set, error_o single pulse on FA cycle+1, state IDLE.
REQ-038 select_i=0, char FA, eng_busy_i stays 0 -> error_o pulse after 16 cycles in WAIT_BUSY, busy_o low after.
REQ-039 valid_i char during DRAIN -> not forwarded, overflow_o=1 until rst_n low.
REQ-040 rst_n low during FORWARD -> all outputs 0 next cycle; new message then processed normally.

Source files
------------

// File: rtl/decryption_scheduler.sv
// rtl/decryption_scheduler.sv - routes ciphertext messages to one of three decryption engines and collects plaintext
module decryption_scheduler #(
    parameter int                 D_WIDTH                = 8,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = D_WIDTH'('hFA),
    parameter int                 TIMEOUT_CYCLES         = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [D_WIDTH-1:0]     data_i,
    input  logic                   valid_i,
    input  logic [1:0]             select_i,
    output logic [D_WIDTH-1:0]     eng_data_o,
    output logic [2:0]             eng_valid_o,
    input  logic [2:0]             eng_busy_i,
    input  logic [3*D_WIDTH-1:0]   eng_data_i,
    input  logic [2:0]             eng_valid_i,
    output logic [D_WIDTH-1:0]     data_o,
    output logic                   valid_o,
    output logic                   busy_o,
    output logic                   msg_done_o,
    output logic [7:0]             out_count_o,
    output logic                   error_o,
    output logic                   overflow_o
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, FORWARD, DISCARD, WAIT_BUSY, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [1:0]           sel_q, sel_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [D_WIDTH-1:0]   eng_data_q, data_q;
    logic [2:0]           eng_valid_q;
    logic                 valid_q, err_q, err_d, ovf_q, done;
    logic [7:0]           out_cnt_q;
    logic                 fwd, is_tok, capture;
    logic [1:0]           fwd_sel;
    logic                 sel_busy, sel_valid;
    logic [D_WIDTH-1:0]   sel_data;

    // Only the latched engine is observed; sel_q==3 never reaches WAIT_BUSY/DRAIN.
    always_comb begin
        sel_busy  = 1'b0;
        sel_valid = 1'b0;
        sel_data  = '0;
        case (sel_q)
            2'd0: begin sel_busy = eng_busy_i[0]; sel_valid = eng_valid_i[0]; sel_data = eng_data_i[0*D_WIDTH +: D_WIDTH]; end
            2'd1: begin sel_busy = eng_busy_i[1]; sel_valid = eng_valid_i[1]; sel_data = eng_data_i[1*D_WIDTH +: D_WIDTH]; end
            2'd2: begin sel_busy = eng_busy_i[2]; sel_valid = eng_valid_i[2]; sel_data = eng_data_i[2*D_WIDTH +: D_WIDTH]; end
            default: ;
        endcase
    end

    assign is_tok  = (data_i == START_DECRYPTION_TOKEN);
    assign capture = (state_q == WAIT_BUSY) || (state_q == DRAIN);
    assign fwd_sel = (state_q == IDLE) ? select_i : sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        fwd     = 1'b0;
        err_d   = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (valid_i) begin
                if (select_i != 2'd3) begin
                    sel_d   = select_i;
                    fwd     = 1'b1;
                    state_d = is_tok ? WAIT_BUSY : FORWARD;
                end else if (is_tok) begin
                    err_d = 1'b1;
                end else begin
                    state_d = DISCARD;
                end
            end
            FORWARD: if (valid_i) begin
                fwd = 1'b1;
                if (is_tok) state_d = WAIT_BUSY;
            end
            DISCARD: if (valid_i && is_tok) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end
            WAIT_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (sel_busy) begin
                    state_d = DRAIN;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: if (!sel_busy) begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == WAIT_BUSY && state_q != WAIT_BUSY) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            sel_q       <= 2'd0;
            cnt_q       <= '0;
            eng_data_q  <= '0;
            eng_valid_q <= 3'b000;
            data_q      <= '0;
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
            out_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            eng_valid_q <= fwd ? (3'b001 << fwd_sel) : 3'b000;
            if (fwd) eng_data_q <= data_i;
            valid_q     <= capture && sel_valid;
            if (capture) data_q <= sel_data;
            if (capture && valid_i) ovf_q <= 1'b1;
            // The count restarts when a message is handed off and saturates rather than wraps.
            if (state_d == WAIT_BUSY && state_q != WAIT_BUSY) begin
                out_cnt_q <= 8'd0;
            end else if (capture && sel_valid && out_cnt_q != 8'd255) begin
                out_cnt_q <= out_cnt_q + 8'd1;
            end
        end
    end

    assign eng_data_o  = eng_data_q;
    assign eng_valid_o = eng_valid_q;
    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign busy_o      = capture;
    assign msg_done_o  = done;
    assign out_count_o = out_cnt_q;
    assign error_o     = err_q;
    assign overflow_o  = ovf_q;
endmodule
